// File: rtl/scan_index_gen_pkg.sv
// Shared types and constants for the scan index generator.
package scan_pkg;

  // Sequencer states; BLANK is only reachable when SCAN_BLANK_EN is defined.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    HOLD  = 2'd2,
    BLANK = 2'd3
  } scan_state_e;

  // Largest channel count the downstream 3-to-8 decoder can address.
  localparam int MAX_CH    = 8;
  localparam int DEF_IDX_W = 3;

  // Counter width for a modulus of div: clog2(div), never narrower than one bit.
  function automatic int PRESC_W(input int div);
    int w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/scan_index_gen_if.sv
// Host/decoder-side signal bundle of the scan index generator.
interface scan_index_gen_if
  import scan_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
);
  logic             start;
  logic             stop;
  logic             mode;
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_ready;
  logic [IDX_W-1:0] idx_out;
  logic             en_out;
  logic             busy;
  logic             sweep_done;

  // Host side: issues commands and hold requests, observes the decoder drive.
  modport master (
    output start, stop, mode, sel_valid, sel_idx,
    input  sel_ready, idx_out, en_out, busy, sweep_done
  );

  // Sequencer side.
  modport slave (
    input  start, stop, mode, sel_valid, sel_idx,
    output sel_ready, idx_out, en_out, busy, sweep_done
  );
endinterface

// File: rtl/scan_index_gen_prescaler.sv
// Step-rate prescaler: counts 0..CLK_DIV-1 while running, ticks on the last count.
module scan_prescaler
  import scan_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic run_i,
  output logic tick_o
);
  localparam int           W    = PRESC_W(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // With CLK_DIV = 1 the counter sits at 0 and ticks every running cycle.
  assign tick_o = run_i && (count_q == LAST);

  // Next count: clear wins, otherwise wrap on tick or hold when not running.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {W{1'b0}};
    end else if (run_i) begin
      if (tick_o) begin
        count_d = {W{1'b0}};
      end else begin
        count_d = count_q + W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/scan_index_gen.sv
// Scan index generator: drives select/enable of the registered 3-to-8 scan decoder.
// Continuous scan, single sweep, or host-held channel.
// Optional macro SCAN_BLANK_EN: blanks en_out for BLANK_CYCLES after every index step.
module scan_index_gen
  import scan_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int NUM_CH       = 8,
  parameter int IDX_W        = DEF_IDX_W,
  parameter int BLANK_CYCLES = 2
) (
  input logic             clk,
  input logic             rst_n,
  scan_index_gen_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mode_q, mode_d;

  logic             running_s;
  logic             clr_s;
  logic             tick_s;
  logic             ready_s;
  logic             accept_s;

`ifdef SCAN_BLANK_EN
  localparam int            BW         = PRESC_W(BLANK_CYCLES);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
  logic [BW-1:0] blank_q, blank_d;
`endif

  assign running_s = (state_q == SCAN) || (state_q == BLANK);
  // Any start or stop realigns the step grid; outside SCAN/BLANK the count is parked at 0.
  assign clr_s     = bus.start || bus.stop || !running_s;
  assign ready_s   = ((state_q == IDLE) || (state_q == HOLD)) && !bus.start && !bus.stop;
  assign accept_s  = bus.sel_valid && ready_s;

  scan_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr_s),
    .run_i  (running_s),
    .tick_o (tick_s)
  );

  // Next state and outputs, priority stop > start > hold request > step tick.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
`ifdef SCAN_BLANK_EN
    blank_d = blank_q;
`endif
    if (bus.stop) begin
      state_d = IDLE;
      en_d    = 1'b0;
    end else if (bus.start) begin
      state_d = SCAN;
      idx_d   = {IDX_W{1'b0}};
      en_d    = 1'b1;
      mode_d  = bus.mode;
    end else if (accept_s) begin
      state_d = HOLD;
      idx_d   = (bus.sel_idx > LAST_CH) ? LAST_CH : bus.sel_idx;
      en_d    = 1'b1;
    end else if (tick_s) begin
      if (mode_q && (idx_q == LAST_CH)) begin
        // End of a single sweep: park on the last channel with the decoder off.
        state_d = IDLE;
        en_d    = 1'b0;
        done_d  = 1'b1;
      end else begin
        idx_d = (idx_q == LAST_CH) ? {IDX_W{1'b0}} : (idx_q + IDX_W'(1));
`ifdef SCAN_BLANK_EN
        state_d = BLANK;
        en_d    = 1'b0;
        blank_d = BLANK_LAST;
`else
        en_d    = 1'b1;
`endif
      end
    end else begin
      case (state_q)
`ifdef SCAN_BLANK_EN
        BLANK: begin
          if (blank_q == {BW{1'b0}}) begin
            state_d = SCAN;
            en_d    = 1'b1;
          end else begin
            blank_d = blank_q - BW'(1);
          end
        end
`endif
        default: begin
          state_d = state_q;
        end
      endcase
    end
    busy_d = (state_d == SCAN) || (state_d == BLANK);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= {IDX_W{1'b0}};
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
    end
  end

`ifdef SCAN_BLANK_EN
  // Remaining blank cycles in the current BLANK phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= {BW{1'b0}};
    end else begin
      blank_q <= blank_d;
    end
  end
`endif

  assign bus.sel_ready  = ready_s;
  assign bus.idx_out    = idx_q;
  assign bus.en_out     = en_q;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = done_q;
endmodule
